// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample default, word-length decode.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package uart_pkg;

   localparam int OVERSAMPLE_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } rx_state_t;

   // Line-control word-length code to data bit count: 00->5 .. 11->8.
   function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
      return 4'd5 + {2'b00, wls};
   endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Synchroniser flop chain bringing the asynchronous serial line into the clk domain.
// Latency: STAGES clk from d to q.
// Backpressure: none; samples every clk, resets to the idle-high line level.
module uart_bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the raw line in at the bottom of the chain.
   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = d;
   end

   // Chain registers; reset to 1 so an idle line never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_top.sv
// 16550-style UART receiver: 16x oversampled, 5-8 data bits, optional parity, one stop bit checked.
// Latency: push 1 clk after the stop-bit mid-sample tick, plus SYNC_STAGES clk of input sync.
// Backpressure: none; push is a one-clk strobe and the RX FIFO must accept it.
module uart_rx_top
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
   parameter int MID_TICK    = OVERSAMPLE / 2 - 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic       rx,
   input  logic       pen,
   input  logic       eps,
   input  logic       sticky_parity,
   input  logic [1:0] wls,
   output logic       push,
   output logic [7:0] dout,
   output logic       pe,
   output logic       fe,
   output logic       bi,
   output logic       rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] MID_T  = TW'(MID_TICK);
   localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);

   logic rx_s;

   uart_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   rx_state_t     state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic [1:0]    wls_q, wls_d;
   logic          pen_q, pen_d, eps_q, eps_d, sticky_q, sticky_d;
   logic          par_bit_q, par_bit_d;
   logic          push_q, push_d;
   logic [7:0]    dout_q, dout_d;
   logic          pe_q, pe_d, fe_q, fe_d, bi_q, bi_d;
   logic          rx_busy_q, rx_busy_d;

   logic          last_data_bit;
   logic          exp_par;
   logic          bit_tick;

   // Frame decode helpers: mid-bit tick, final data bit, and the parity value this frame expects.
   always_comb begin
      bit_tick      = (tick_q == LAST_T);
      last_data_bit = ({1'b0, bit_q} == (wls_to_bits(wls_q) - 4'd1));
      exp_par       = sticky_q ? ~eps_q : (eps_q ? ^data_q : ~^data_q);
   end

   // Next-state and next-output logic; nothing moves without a baud tick.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      data_d    = data_q;
      wls_d     = wls_q;
      pen_d     = pen_q;
      eps_d     = eps_q;
      sticky_d  = sticky_q;
      par_bit_d = par_bit_q;
      push_d    = 1'b0;
      dout_d    = dout_q;
      pe_d      = pe_q;
      fe_d      = fe_q;
      bi_d      = bi_q;
      if (baud_pulse) begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  tick_d  = '0;
               end
            end
            START: begin
               if (tick_q == MID_T) begin
                  if (rx_s) begin
                     state_d = IDLE;
                  end else begin
                     // Start bit confirmed: freeze line control for this frame.
                     state_d   = DATA;
                     tick_d    = '0;
                     bit_d     = '0;
                     data_d    = '0;
                     par_bit_d = 1'b0;
                     wls_d     = wls;
                     pen_d     = pen;
                     eps_d     = eps;
                     sticky_d  = sticky_parity;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            DATA: begin
               if (bit_tick) begin
                  tick_d        = '0;
                  data_d[bit_q] = rx_s;
                  if (last_data_bit) begin
                     bit_d   = '0;
                     state_d = pen_q ? PARITY : STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            PARITY: begin
               if (bit_tick) begin
                  tick_d    = '0;
                  par_bit_d = rx_s;
                  state_d   = STOP;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            STOP: begin
               if (bit_tick) begin
                  tick_d  = '0;
                  push_d  = 1'b1;
                  dout_d  = data_q;
                  pe_d    = pen_q & (par_bit_q != exp_par);
                  fe_d    = ~rx_s;
                  bi_d    = (data_q == 8'h00) & (~pen_q | ~par_bit_q) & ~rx_s;
                  // A low stop bit may be a break; wait for the line to recover before rearming.
                  state_d = rx_s ? IDLE : BREAK_WAIT;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            BREAK_WAIT: begin
               if (rx_s) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      rx_busy_d = (state_d != IDLE) && (state_d != BREAK_WAIT);
   end

   // All receiver state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         data_q    <= '0;
         wls_q     <= '0;
         pen_q     <= 1'b0;
         eps_q     <= 1'b0;
         sticky_q  <= 1'b0;
         par_bit_q <= 1'b0;
         push_q    <= 1'b0;
         dout_q    <= '0;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
         bi_q      <= 1'b0;
         rx_busy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         data_q    <= data_d;
         wls_q     <= wls_d;
         pen_q     <= pen_d;
         eps_q     <= eps_d;
         sticky_q  <= sticky_d;
         par_bit_q <= par_bit_d;
         push_q    <= push_d;
         dout_q    <= dout_d;
         pe_q      <= pe_d;
         fe_q      <= fe_d;
         bi_q      <= bi_d;
         rx_busy_q <= rx_busy_d;
      end
   end

   assign push    = push_q;
   assign dout    = dout_q;
   assign pe      = pe_q;
   assign fe      = fe_q;
   assign bi      = bi_q;
   assign rx_busy = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Bench for uart_rx_top: directed frames plus randomized frames against a frame-level model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_uart_rx_top;

   localparam int BIT_CLK = 96;   // 16 ticks x 6 clk per tick

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_pulse = 1'b0;
   logic       rx;
   logic       pen, eps, sticky_parity;
   logic [1:0] wls;
   logic       push;
   logic [7:0] dout;
   logic       pe, fe, bi, rx_busy;

   uart_rx_top dut (
      .clk           (clk),
      .rst           (rst),
      .baud_pulse    (baud_pulse),
      .rx            (rx),
      .pen           (pen),
      .eps           (eps),
      .sticky_parity (sticky_parity),
      .wls           (wls),
      .push          (push),
      .dout          (dout),
      .pe            (pe),
      .fe            (fe),
      .bi            (bi),
      .rx_busy       (rx_busy)
   );

   always #5 clk = ~clk;

   // Baud tick: one clk high out of every six, changed on the falling edge.
   int bcnt = 0;
   always @(negedge clk) begin
      bcnt       = (bcnt == 5) ? 0 : bcnt + 1;
      baud_pulse = (bcnt == 0);
   end

   typedef struct packed {
      logic [7:0] dout;
      logic       pe;
      logic       fe;
      logic       bi;
   } res_t;

   res_t exp_q[$];
   res_t exp_r;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_push = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Frame-level reference: what a receiver must report for the bits put on the line.
   function automatic res_t model(input logic [7:0] data, input logic [1:0] w, input logic p,
                                  input logic e, input logic s, input logic par, input logic stop);
      res_t r;
      int   n     = 5 + int'(w);
      int   ones  = 0;
      logic ppar;
      r.dout = 8'h00;
      for (int i = 0; i < n; i++) r.dout[i] = data[i];
      for (int i = 0; i < 8; i++) ones += int'(r.dout[i]);
      if (s)      ppar = ~e;                       // forced parity level
      else if (e) ppar = (ones % 2) == 1;          // even: total ones incl. parity is even
      else        ppar = (ones % 2) == 0;          // odd
      r.pe = p && (par != ppar);
      r.fe = ~stop;
      r.bi = (r.dout == 8'h00) && (!p || !par) && !stop;
      return r;
   endfunction

   // Every push is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (push === 1'b1) begin
         n_push++;
         if (exp_q.size() == 0) begin
            check("push_unexpected", 32'(push), 32'd0);
         end else begin
            exp_r = exp_q.pop_front();
            check("dout", 32'(dout), 32'(exp_r.dout));
            check("pe",   32'(pe),   32'(exp_r.pe));
            check("fe",   32'(fe),   32'(exp_r.fe));
            check("bi",   32'(bi),   32'(exp_r.bi));
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cfg(input logic [1:0] w, input logic p, input logic e, input logic s);
      wls = w; pen = p; eps = e; sticky_parity = s;
   endtask

   // Drive one frame; optionally scramble line control once the start bit is past.
   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                             input bit scramble);
      int n = 5 + int'(wls);
      logic p = pen;
      rx = 1'b0;
      wait_clk(BIT_CLK);
      if (scramble) set_cfg(2'($urandom_range(3)), 1'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < n; i++) begin
         rx = data[i];
         wait_clk(BIT_CLK);
      end
      if (p) begin
         rx = par;
         wait_clk(BIT_CLK);
      end
      rx = stop;
      wait_clk(BIT_CLK);
      rx = 1'b1;
      wait_clk(2 * BIT_CLK);
   endtask

   int n0;

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      set_cfg(2'b11, 1'b1, 1'b1, 1'b0);
      wait_clk(5);
      check("rst_push",    32'(push),    32'd0);
      check("rst_dout",    32'(dout),    32'd0);
      check("rst_pe",      32'(pe),      32'd0);
      check("rst_fe",      32'(fe),      32'd0);
      check("rst_bi",      32'(bi),      32'd0);
      check("rst_busy",    32'(rx_busy), 32'd0);
      rst = 1'b0;
      wait_clk(2 * BIT_CLK);

      // 8N-even, good parity
      set_cfg(2'b11, 1'b1, 1'b1, 1'b0);
      exp_q.push_back('{dout: 8'h13, pe: 1'b0, fe: 1'b0, bi: 1'b0});
      send_frame(8'h13, 1'b1, 1'b1, 1'b0);
      // same frame, wrong parity
      exp_q.push_back('{dout: 8'h13, pe: 1'b1, fe: 1'b0, bi: 1'b0});
      send_frame(8'h13, 1'b0, 1'b1, 1'b0);
      // 5 bits, no parity, stop bit low
      set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
      exp_q.push_back('{dout: 8'h15, pe: 1'b0, fe: 1'b1, bi: 1'b0});
      send_frame(8'h15, 1'b0, 1'b0, 1'b0);
      check("pending_directed", 32'(exp_q.size()), 32'd0);

      // Break: line low for 20 bit times yields one push only
      set_cfg(2'b11, 1'b1, 1'b1, 1'b0);
      exp_q.push_back('{dout: 8'h00, pe: 1'b0, fe: 1'b1, bi: 1'b1});
      n0 = n_push;
      rx = 1'b0;
      wait_clk(20 * BIT_CLK);
      rx = 1'b1;
      wait_clk(3 * BIT_CLK);
      check("break_push_count", 32'(n_push - n0), 32'd1);
      exp_q.push_back('{dout: 8'hC6, pe: 1'b0, fe: 1'b0, bi: 1'b0});
      send_frame(8'hC6, 1'b0, 1'b1, 1'b0);
      check("after_break_count", 32'(n_push - n0), 32'd2);

      // Glitch of 4 ticks is a false start
      n0 = n_push;
      rx = 1'b0;
      wait_clk(18);
      check("glitch_busy", 32'(rx_busy), 32'd1);
      wait_clk(6);
      rx = 1'b1;
      wait_clk(2 * BIT_CLK);
      check("glitch_push_count", 32'(n_push - n0), 32'd0);
      check("glitch_idle",       32'(rx_busy),      32'd0);

      // Sticky parity: expected parity bit is ~eps = 1
      set_cfg(2'b11, 1'b1, 1'b0, 1'b1);
      exp_q.push_back('{dout: 8'hA5, pe: 1'b0, fe: 1'b0, bi: 1'b0});
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
      exp_q.push_back('{dout: 8'hA5, pe: 1'b1, fe: 1'b0, bi: 1'b0});
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);

      // Reset in the middle of the data bits abandons the frame
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      n0 = n_push;
      rx = 1'b0;
      wait_clk(BIT_CLK);
      rx = 1'b1;
      wait_clk(BIT_CLK);
      rx = 1'b0;
      wait_clk(BIT_CLK / 2);
      check("busy_in_data", 32'(rx_busy), 32'd1);
      rst = 1'b1;
      rx  = 1'b1;
      wait_clk(3);
      check("midrst_push", 32'(push),    32'd0);
      check("midrst_dout", 32'(dout),    32'd0);
      check("midrst_pe",   32'(pe),      32'd0);
      check("midrst_fe",   32'(fe),      32'd0);
      check("midrst_bi",   32'(bi),      32'd0);
      check("midrst_busy", 32'(rx_busy), 32'd0);
      rst = 1'b0;
      wait_clk(3 * BIT_CLK);
      check("midrst_push_count", 32'(n_push - n0), 32'd0);
      exp_q.push_back('{dout: 8'h3C, pe: 1'b0, fe: 1'b0, bi: 1'b0});
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0);

      // Randomized frames; line control scrambled after each start bit
      for (int k = 0; k < 20; k++) begin
         logic [7:0] d;
         logic       par, stop;
         set_cfg(2'($urandom_range(3)), 1'($urandom), 1'($urandom), 1'($urandom));
         d    = 8'($urandom);
         if ($urandom_range(7) == 0) d = 8'h00;
         par  = 1'($urandom);
         stop = ($urandom_range(3) != 0);
         exp_q.push_back(model(d, wls, pen, eps, sticky_parity, par, stop));
         send_frame(d, par, stop, 1'b1);
      end

      wait_clk(BIT_CLK);
      check("pending_final", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
16550-style UART receiver, the receive-side counterpart of uart_tx_top. It shares that block's baud tick and line-control signals (wls, pen, eps, sticky_parity). It oversamples the serial input at 16x baud_pulse, confirms the start bit, and deserialises 5-8 data bits LSB first. It then checks parity and the first stop bit, and pushes one character plus error flags per frame toward the RX FIFO.

Parameters:
OVERSAMPLE, 16, baud_pulse ticks per bit time.
MID_TICK, 7, tick index (0-based) at which each bit is sampled; equals OVERSAMPLE/2-1.
SYNC_STAGES, 2, flops on rx before use.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
baud_pulse  input  1  one-clk-wide 16x-baud enable
rx  input  1  serial line, idle high, asynchronous
pen  input  1  parity enable
eps  input  1  1 = even parity, 0 = odd
sticky_parity  input  1  with pen=1: expected parity bit = ~eps
wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits
push  output  1  one-clk pulse, received character valid
dout  output  8  received data, zero-extended above word length
pe  output  1  parity error for pushed character
fe  output  1  framing error (first stop bit sampled 0)
bi  output  1  break indicator
rx_busy  output  1  high in any state other than IDLE and BREAK_WAIT

Behaviour:
- Clock and reset: one clock clk; rst synchronous, active-high. All state updates on posedge clk.
- Reset values: state=IDLE, tick counter=0, bit counter=0, sync flops=1, push=0, dout=0, pe=0, fe=0, bi=0, rx_busy=0.
- Reset mid-frame: abandon the frame with no push; same reset values apply.
- All sampling and counting advance only on cycles where baud_pulse=1. With no tick, the state holds.
- rx_s is the output of the SYNC_STAGES synchroniser; only rx_s is used.
- IDLE: on a tick with rx_s=0, go to START with tick counter=0.
- START: count ticks. At tick MID_TICK:
  - rx_s=1 -> false start, back to IDLE, no push.
  - rx_s=0 -> latch wls/pen/eps/sticky_parity for the frame, go to DATA, restart the tick count.
  - Later config changes do not affect the frame in progress.
- DATA: sample rx_s once per OVERSAMPLE ticks (mid-bit) and shift in LSB first. After N = 5 + wls bits, go to PARITY if pen=1, else STOP.
- PARITY: sample one bit. Expected value:
  - sticky_parity=1: ~eps.
  - eps=1: XOR of the data bits.
  - eps=0: XNOR of the data bits.
  - pe = (sample != expected).
  - pen=0: pe=0.
- STOP: sample the first stop bit only; a second stop bit is never checked. fe = ~sample.
  - bi=1 iff all data bits, the parity bit (if enabled) and the stop bit were 0.
  - On the clk after the stop sample: push=1 for exactly one cycle. dout/pe/fe/bi update in the same cycle and hold until the next push.
  - Next state: BREAK_WAIT if rx_s=0 at the stop sample, else IDLE.
  - Returning to IDLE at mid-stop allows back-to-back frames.
- BREAK_WAIT: stay until a tick sees rx_s=1, then go to IDLE. A line held low produces exactly one push.
- Latency: push is 1 clk after the stop-bit mid-sample tick, plus SYNC_STAGES clks of input delay.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - OVERSAMPLE default constant.
  - Function wls_to_bits (2-bit code -> 5..8). Reuse it in uart_tx_top.
- One sub-module: uart_bit_sync, a SYNC_STAGES flop chain with reset value 1.

Test Plan:
- Bench setup for every scenario: baud_pulse every 6 clk; each bit is 16 ticks.
- wls=11, pen=1, eps=1, sticky=0; send 0x13 with parity 1 and stop 1 -> one push, dout=0x13, pe=0, fe=0, bi=0.
- Same frame with parity bit 0 -> dout=0x13, pe=1, fe=0.
- wls=00, pen=0; send 0x15 with stop bit 0, then line high -> dout=0x15, fe=1, bi=0, pe=0.
- wls=11, pen=1, eps=1; rx held low for 20 bit times, then high -> exactly one push:
  - dout=0x00, bi=1, fe=1, pe=0.
  - No further push until a new frame is sent; that frame then receives correctly.
- rx pulse low for 4 ticks only -> no push, rx_busy returns to 0.
- pen=1, sticky=1, eps=0; send 0xA5 with parity 1 -> pe=0; parity 0 -> pe=1.
- Assert rst during DATA -> no push, all outputs 0; the next frame receives correctly.
